// File: rtl/skinny_sbox8_dom1_serial_ctrl.sv
// Byte-serial sequencer for one shared DOM-1 SKINNY 8-bit S-box: presents each
// two-share byte with a fresh mask, holds it for the S-box latency, collects results.
module skinny_sbox8_dom1_serial_ctrl #(
  parameter int unsigned NBYTES  = 16,
  parameter int unsigned LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic [8*NBYTES-1:0] state_in1,
  input  logic [8*NBYTES-1:0] state_in0,
  output logic [8*NBYTES-1:0] state_out1,
  output logic [8*NBYTES-1:0] state_out0,
  input  logic [7:0]          rnd_in,
  input  logic                rnd_valid,
  output logic                rnd_ready,
  output logic [7:0]          sb_si1,
  output logic [7:0]          sb_si0,
  output logic [7:0]          sb_r,
  input  logic [7:0]          sb_bo1,
  input  logic [7:0]          sb_bo0
);
  localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned CNT_W = $clog2(LATENCY) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, LOAD, EVAL, DONE} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [NBYTES-1:0][7:0] in1_b, in0_b, out1_q, out0_q;
  logic                   load_fire, eval_last;

  assign in1_b      = state_in1;
  assign in0_b      = state_in0;
  assign state_out1 = out1_q;
  assign state_out0 = out0_q;

  // Mask handshake only completes while waiting for a byte's mask.
  assign rnd_ready = rnd_valid && (state_q == LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    load_fire = 1'b0;
    eval_last = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        if (rnd_valid) begin
          load_fire = 1'b1;
          state_d   = EVAL;
        end
      end
      EVAL: begin
        if (cnt_q == CNT_LAST) begin
          eval_last = 1'b1;
          state_d   = (idx_q == IDX_LAST) ? DONE : LOAD;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // S-box bus, byte index, latency counter and result collection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy   <= 1'b0;
      done   <= 1'b0;
      idx_q  <= '0;
      cnt_q  <= '0;
      sb_si1 <= '0;
      sb_si0 <= '0;
      sb_r   <= '0;
      out1_q <= '0;
      out0_q <= '0;
    end else begin
      busy <= (state_d != IDLE);
      done <= (state_d == DONE);
      if ((state_q == IDLE) && start) idx_q <= '0;
      if (load_fire) begin
        sb_si1 <= in1_b[idx_q];
        sb_si0 <= in0_b[idx_q];
        sb_r   <= rnd_in;
        cnt_q  <= '0;
      end
      if (state_q == EVAL) cnt_q <= cnt_q + CNT_W'(1);
      if (eval_last) begin
        out1_q[idx_q] <= sb_bo1;
        out0_q[idx_q] <= sb_bo0;
        if (idx_q != IDX_LAST) idx_q <= idx_q + IDX_W'(1);
      end
      // Leave no share on the S-box bus once the layer is complete.
      if (state_q == DONE) begin
        sb_si1 <= '0;
        sb_si0 <= '0;
        sb_r   <= '0;
      end
    end
  end
endmodule

// File: tb/tb_skinny_sbox8_dom1_serial_ctrl.sv
// Scoreboard bench for the serial S-box sequencer with a behavioural
// pipelined DOM-1 S-box that only yields correct shares after LATENCY stable cycles.
module tb_skinny_sbox8_dom1_serial_ctrl;
  localparam int unsigned NBYTES  = 16;
  localparam int unsigned LAT     = 4;
  localparam int unsigned W       = 8 * NBYTES;
  localparam int unsigned RUN_CYC = NBYTES * (1 + LAT);

  logic         clk = 1'b0;
  logic         rst, start, busy, done, rnd_valid, rnd_ready;
  logic [W-1:0] state_in1, state_in0, state_out1, state_out0;
  logic [7:0]   rnd_in, sb_si1, sb_si0, sb_r, sb_bo1, sb_bo0;

  always #5 clk = ~clk;

  skinny_sbox8_dom1_serial_ctrl #(.NBYTES(NBYTES), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .state_in1(state_in1), .state_in0(state_in0),
    .state_out1(state_out1), .state_out0(state_out0),
    .rnd_in(rnd_in), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .sb_si1(sb_si1), .sb_si0(sb_si0), .sb_r(sb_r),
    .sb_bo1(sb_bo1), .sb_bo0(sb_bo0)
  );

  function automatic logic [7:0] mix(input logic [7:0] x);
    return ((~(((x >> 1) | x) >> 2)) & 8'h11) ^ x;
  endfunction
  function automatic logic [7:0] perm(input logic [7:0] x);
    return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
           ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
  endfunction
  function automatic logic [7:0] sbox8(input logic [7:0] xin);
    logic [7:0] x;
    x = xin;
    for (int i = 0; i < 3; i++) x = perm(mix(x));
    x = mix(x);
    return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
  endfunction
  function automatic logic [W-1:0] sbox_state(input logic [W-1:0] x);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < NBYTES; i++) r[8*i +: 8] = sbox8(x[8*i +: 8]);
    return r;
  endfunction

  // S-box model: LAT-1 register stages, output shares recombine to S(si1^si0).
  logic [23:0] pipe [LAT-1];
  always @(posedge clk) begin
    pipe[0] <= {sb_si1, sb_si0, sb_r};
    for (int i = 1; i < LAT - 1; i++) pipe[i] <= pipe[i-1];
  end
  always_comb begin
    sb_bo0 = pipe[LAT-2][7:0];
    sb_bo1 = sbox8(pipe[LAT-2][23:16] ^ pipe[LAT-2][15:8]) ^ pipe[LAT-2][7:0];
  end

  typedef struct packed {
    logic [W-1:0] res;
    int unsigned  t0;
    int unsigned  lat;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int unsigned done_cnt = 0;
  int          rr_cnt = 0;
  logic [23:0] exp_sb = '0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) rnd_in = 8'($urandom);

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: S-box bus must hold the last handshaken byte; done pops the scoreboard.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      exp_sb = '0;
      rr_cnt = 0;
    end else begin
      chk("sb_bus", W'({sb_si1, sb_si0, sb_r}), W'(exp_sb));
      if (rnd_ready) begin
        if (rr_cnt < NBYTES)
          exp_sb = {state_in1[8*rr_cnt +: 8], state_in0[8*rr_cnt +: 8], rnd_in};
        rr_cnt++;
      end
      if (done) begin
        done_cnt++;
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done pulse expected none (t=%0t)", $time);
        end else begin
          mon_e = sbq.pop_front();
          chk("result", state_out1 ^ state_out0, mon_e.res);
          chk("latency", W'(cyc - mon_e.t0), W'(mon_e.lat));
          chk("rnd_ready_count", W'(rr_cnt), W'(NBYTES));
        end
        rr_cnt = 0;
        exp_sb = '0;
      end
    end
  end

  task automatic start_run(input logic [W-1:0] s1, input logic [W-1:0] s0,
                           input logic [W-1:0] res, input int unsigned lat);
    @(negedge clk);
    state_in1 = s1;
    state_in0 = s0;
    start     = 1'b1;
    sbq.push_back('{res: res, t0: cyc + 1, lat: lat});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int unsigned target);
    int unsigned n;
    n = 0;
    while (done_cnt < target && n < 4 * RUN_CYC) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", W'(done_cnt), W'(target));
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, W'(busy), W'(0));
    chk({tag, "_done"}, W'(done), W'(0));
    chk({tag, "_rnd_ready"}, W'(rnd_ready), W'(0));
    chk({tag, "_sb"}, W'({sb_si1, sb_si0, sb_r}), W'(0));
    chk({tag, "_out1"}, state_out1, W'(0));
    chk({tag, "_out0"}, state_out0, W'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [W-1:0] r_mask, s1, s0;
  int unsigned  n, t0;

  initial begin
    rst = 1'b1; start = 1'b0; rnd_valid = 1'b1;
    state_in1 = '0; state_in0 = '0;
    repeat (3) @(negedge clk);
    #1 chk_quiet("reset");
    @(negedge clk) rst = 1'b0;

    // Zero state: every unmasked byte is S(0) = 0x65.
    start_run('0, '0, {NBYTES{8'h65}}, RUN_CYC);
    wait_done(1);

    // Masked all-ones state: unmasked result is S(0xFF) = 0xFF.
    r_mask = {$urandom, $urandom, $urandom, $urandom};
    start_run(r_mask, {NBYTES{8'hFF}} ^ r_mask, {NBYTES{8'hFF}}, RUN_CYC);
    wait_done(2);

    // Mixed vector with a 3-cycle mask stall on byte 5.
    s1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    s0 = 128'h5A5A_0F0F_3C3C_9696_A5A5_F0F0_C3C3_6969;
    start_run(s1, s0, sbox_state(s1 ^ s0), RUN_CYC + 3);
    n = 0;
    while (rr_cnt < 5 && n < 4 * RUN_CYC) begin
      @(negedge clk);
      n++;
    end
    chk("stall_reach_byte5", W'(rr_cnt), W'(5));
    repeat (LAT - 1) @(negedge clk);
    rnd_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("stall_rnd_ready", W'(rnd_ready), W'(0));
      chk("stall_busy", W'(busy), W'(1));
    end
    @(negedge clk) rnd_valid = 1'b1;
    wait_done(3);

    // Start pulse while busy is ignored.
    start_run(s0, s1, sbox_state(s1 ^ s0), RUN_CYC);
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk) start = 1'b0;
    wait_done(4);
    repeat (RUN_CYC + 10) @(negedge clk);
    chk("no_second_run_done", W'(done_cnt), W'(4));
    chk("no_second_run_busy", W'(busy), W'(0));

    // Start held high through DONE, dropped in the following IDLE cycle.
    @(negedge clk);
    state_in1 = r_mask;
    state_in0 = r_mask;
    start     = 1'b1;
    sbq.push_back('{res: {NBYTES{8'h65}}, t0: cyc + 1, lat: RUN_CYC});
    wait_done(5);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("held_start_busy", W'(busy), W'(0));
    chk("held_start_done_cnt", W'(done_cnt), W'(5));

    // Asynchronous reset mid-run, then a clean full run.
    start_run(s1, s0, sbox_state(s1 ^ s0), RUN_CYC);
    t0 = cyc - 1;
    while (cyc < t0 + 37) @(negedge clk);
    #3 rst = 1'b1;
    #1 chk_quiet("midrun_reset");
    sbq.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    start_run('0, '0, {NBYTES{8'h65}}, RUN_CYC);
    wait_done(6);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", W'(sbq.size()), W'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
